timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter READY_THRESHOLD, default 9: largest pending M-cycle count at which oTickReady is asserted.
REQ-002 iClock  input  1  single clock; all state changes on its rising edge.
REQ-003 iReset  input  1  asynchronous, active-high reset.
REQ-004 iTickValid  input  1  upstream offers elapsed M-cycles; held until accepted.
REQ-005 iTickCount  input  3  M-cycles offered, 0-6.
REQ-006 oTickReady  output  1  controller accepts a tick this cycle.
REQ-007 iAddr  input  2  register select: 0 DIV, 1 TIMA, 2 TMA, 3 TAC.
REQ-008 iWe  input  1  register write strobe, one clock per write.
REQ-009 iWData  input  8  write data.
REQ-010 oRData  output  8  combinational read data for iAddr.
REQ-011 oDiv, oTima  output  8 each  current DIV and TIMA values.
REQ-012 oInterrupt0x50  output  1  timer interrupt request, one-clock pulse.

Function
REQ-013 Tick acceptance: a tick is accepted when iTickValid & oTickReady in the same clock; oTickReady = (pending <= READY_THRESHOLD); pending is 4 bits and never wraps.
REQ-014 Accept and drain may occur in the same clock: pending_next = pending + iTickCount(if accepted) - 1(if draining).
REQ-015 Drain: when pending > 0, exactly one M-cycle is processed per clock; the 14-bit M-cycle system counter increments by 1 and wraps 0x3FFF->0.
REQ-016 DIV = system counter bits [13:6]; oRData for DIV returns this value.
REQ-017 Timer input = TAC[2] AND selected counter bit: TAC[1:0] 00->bit7, 01->bit1, 10->bit3, 11->bit5.
REQ-018 TIMA increments by 1 on each 1->0 transition of the timer input, whatever the cause (counting, DIV write, TAC write).
REQ-019 FSM states: ST_IDLE (pending = 0), ST_COUNT (draining), ST_RELOAD (overflow pending); ST_IDLE<->ST_COUNT follows pending != 0.
REQ-020 Overflow: TIMA 0xFF increment -> TIMA = 0x00, enter ST_RELOAD.
REQ-021 ST_RELOAD: on the next processed M-cycle, TIMA <= TMA (current value, including a TMA write in the same clock), oInterrupt0x50 = 1 for that single clock, then return to ST_COUNT or ST_IDLE.
REQ-022 ST_RELOAD persists with no draining; the reload waits for a processed M-cycle.
REQ-023 A TIMA write while in ST_RELOAD cancels the reload and interrupt; TIMA takes the written value and the FSM leaves ST_RELOAD.
REQ-024 Writes: DIV write (any data) clears the system counter to 0; TIMA write loads iWData; TMA write loads iWData; TAC write loads iWData[2:0].
REQ-025 A CPU write to TIMA in the same clock as an increment: the write wins, no increment.
REQ-026 A DIV or TAC write in the same clock as a drain: the write is applied after the drain; the falling-edge check uses the post-write value.
REQ-027 TAC read returns {5'b11111, TAC[2:0]}; reads have no side effects.
REQ-028 An interrupt is never generated when TAC[2] = 0, except by a reload already in ST_RELOAD.

Reset
REQ-029 Asynchronous reset: system counter 0, pending 0, TIMA 0, TMA 0, TAC 0, FSM ST_IDLE, oInterrupt0x50 0, oTickReady 1.
REQ-030 Reset mid-operation discards pending M-cycles and any ST_RELOAD without an interrupt.

Verification
REQ-031 TAC=0x05, TIMA=0x00, offer 16 ticks of count 1 -> TIMA=0x04, pending drains to 0, no interrupt.
REQ-032 TAC=0x05, TMA=0xAB, TIMA=0xFF, process 4 M-cycles -> TIMA=0x00 one M-cycle, then 0xAB with a single oInterrupt0x50 pulse.
REQ-033 Same as REQ-032 but write TIMA=0x10 during ST_RELOAD -> TIMA=0x10, no interrupt.
REQ-034 TAC=0x04, system counter bit7=1, write DIV -> counter 0, DIV=0x00, TIMA increments by 1 (falling-edge glitch).
REQ-035 Hold iTickValid with count 6 while pending=9 then 10 -> accepted at 9 (pending 15 minus drain), oTickReady low at 10+, no pending wrap.
REQ-036 Assert iReset while pending=7 and in ST_RELOAD -> all REQ-029 values immediately, no interrupt pulse.

Source files
------------

// File: rtl/timer_ctrl.sv
// Divider/timer block: drains offered M-cycles one per clock into a 14-bit system counter,
// counts TIMA on falling edges of the selected counter bit, reloads from TMA with an interrupt pulse.
module timer_ctrl #(
  parameter int unsigned READY_THRESHOLD = 9
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTickValid,
  input  logic [2:0] iTickCount,
  output logic       oTickReady,
  input  logic [1:0] iAddr,
  input  logic       iWe,
  input  logic [7:0] iWData,
  output logic [7:0] oRData,
  output logic [7:0] oDiv,
  output logic [7:0] oTima,
  output logic       oInterrupt0x50
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_RELOAD} state_t;

  state_t      state_q;
  logic [3:0]  pending_q, pending_d;
  logic [13:0] cnt_q, cnt_d;
  logic [7:0]  tima_q, tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        irq_q;
  logic        drain, accept, fall, tima_we;
  logic [4:0]  pend_sum;

  function automatic logic timer_in(input logic [13:0] c, input logic [2:0] t);
    logic sel;
    case (t[1:0])
      2'b00:   sel = c[7];
      2'b01:   sel = c[1];
      2'b10:   sel = c[3];
      default: sel = c[5];
    endcase
    return t[2] & sel;
  endfunction

  assign oTickReady     = (32'(pending_q) <= READY_THRESHOLD);
  assign oDiv           = cnt_q[13:6];
  assign oTima          = tima_q;
  assign oInterrupt0x50 = irq_q;

  always_comb begin
    drain    = (pending_q != 4'd0);
    accept   = iTickValid & oTickReady;
    tima_we  = iWe && (iAddr == 2'd1);
    pend_sum = {1'b0, pending_q} + (accept ? {2'b00, iTickCount} : 5'd0) - {4'd0, drain};
    pending_d = (pend_sum > 5'd15) ? 4'hF : pend_sum[3:0];
    // Register writes land after this clock's drain, so the edge check sees the post-write value.
    cnt_d = drain ? cnt_q + 14'd1 : cnt_q;
    if (iWe && (iAddr == 2'd0)) cnt_d = '0;
    tac_d = (iWe && (iAddr == 2'd3)) ? iWData[2:0] : tac_q;
    tma_d = (iWe && (iAddr == 2'd2)) ? iWData : tma_q;
    fall  = timer_in(cnt_q, tac_q) & ~timer_in(cnt_d, tac_d);
  end

  always_comb begin
    case (iAddr)
      2'd0:    oRData = cnt_q[13:6];
      2'd1:    oRData = tima_q;
      2'd2:    oRData = tma_q;
      default: oRData = {5'b11111, tac_q};
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pending_q <= '0;
      cnt_q     <= '0;
      tac_q     <= '0;
      tma_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      tac_q     <= tac_d;
      tma_q     <= tma_d;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      tima_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q   <= 1'b0;
      state_q <= (pending_d != 4'd0) ? ST_COUNT : ST_IDLE;
      if (state_q == ST_RELOAD) begin
        // A CPU write to TIMA aborts the pending reload and its interrupt.
        if (tima_we) begin
          tima_q <= iWData;
        end else if (drain) begin
          tima_q <= tma_d;
          irq_q  <= 1'b1;
        end else begin
          state_q <= ST_RELOAD;
        end
      end else if (tima_we) begin
        tima_q <= iWData;
      end else if (fall) begin
        if (tima_q == 8'hFF) begin
          tima_q  <= 8'h00;
          state_q <= ST_RELOAD;
        end else begin
          tima_q <= tima_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iTickValid = 1'b0;
  logic [2:0] iTickCount = 3'd0;
  logic       oTickReady;
  logic [1:0] iAddr = 2'd0;
  logic       iWe = 1'b0;
  logic [7:0] iWData = 8'd0;
  logic [7:0] oRData, oDiv, oTima;
  logic       oInterrupt0x50;

  int n_chk = 0;
  int n_err = 0;
  int irq_cnt = 0;

  timer_ctrl #(.READY_THRESHOLD(9)) dut (
    .iClock(iClock), .iReset(iReset), .iTickValid(iTickValid), .iTickCount(iTickCount),
    .oTickReady(oTickReady), .iAddr(iAddr), .iWe(iWe), .iWData(iWData), .oRData(oRData),
    .oDiv(oDiv), .oTima(oTima), .oInterrupt0x50(oInterrupt0x50)
  );

  always #5 iClock = ~iClock;

  always @(negedge iClock) if (oInterrupt0x50) irq_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge iClock);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iAddr = a; iWData = d; iWe = 1'b1;
    step(1);
    iWe = 1'b0;
  endtask

  task automatic offer(input logic [2:0] c);
    int k = 0;
    iTickValid = 1'b1; iTickCount = c;
    while (!oTickReady && k < 50) begin
      step(1);
      k++;
    end
    if (k >= 50) chk("offer_timeout", 0, 1);
    step(1);
    iTickValid = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int k = 0;
    while (dut.pending_q != 4'd0 && k < 200) begin
      step(1);
      k++;
    end
    chk(tag, int'(dut.pending_q), 0);
  endtask

  int exp_pend[5] = '{6, 11, 10, 9, 14};
  int exp_rdy[5]  = '{1, 0, 0, 1, 0};

  initial begin
    step(2);
    // Reset values
    chk("rst_ready", oTickReady, 1);
    chk("rst_div", oDiv, 0);
    chk("rst_tima", oTima, 0);
    chk("rst_irq", oInterrupt0x50, 0);
    iAddr = 2'd3; #1;
    chk("rst_tac_read", oRData, 8'hF8);
    iReset = 1'b0;
    step(1);

    // 16 single ticks with TAC=05 -> 4 falling edges of bit 1
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h05);
    wr(2'd1, 8'h00);
    for (int i = 0; i < 16; i++) offer(3'd1);
    step(3);
    chk("t31_pending", int'(dut.pending_q), 0);
    chk("t31_tima", oTima, 8'h04);
    chk("t31_irq", irq_cnt, 0);
    iAddr = 2'd3; #1;
    chk("t31_tac_read", oRData, 8'hFD);

    // Overflow then reload from TMA with one interrupt pulse
    wr(2'd0, 8'h00);
    wr(2'd2, 8'hAB);
    wr(2'd1, 8'hFF);
    offer(3'd4);
    step(4);
    chk("t32_tima_zero", oTima, 8'h00);
    step(3);
    chk("t32_reload_waits", oTima, 8'h00);
    chk("t32_no_irq_yet", irq_cnt, 0);
    offer(3'd1);
    step(2);
    chk("t32_tima_tma", oTima, 8'hAB);
    chk("t32_irq_once", irq_cnt, 1);

    // TIMA write during reload cancels it
    wr(2'd0, 8'h00);
    wr(2'd1, 8'hFF);
    offer(3'd4);
    step(4);
    chk("t33_tima_zero", oTima, 8'h00);
    wr(2'd1, 8'h10);
    offer(3'd1);
    step(3);
    chk("t33_tima_written", oTima, 8'h10);
    chk("t33_no_irq", irq_cnt, 1);

    // DIV write while selected bit 7 is high -> glitch increment
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h04);
    for (int i = 0; i < 22; i++) offer(3'd6);
    wait_drained("t34_drained");
    chk("t34_div_132", oDiv, 8'h02);
    chk("t34_tima_before", oTima, 8'h10);
    wr(2'd0, 8'h5A);
    iAddr = 2'd0; #1;
    chk("t34_div_read", oRData, 8'h00);
    chk("t34_div_cnt", int'(dut.cnt_q), 0);
    chk("t34_tima_glitch", oTima, 8'h11);

    // Backpressure around the threshold, no pending wrap
    iTickValid = 1'b1; iTickCount = 3'd6;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("t35_pending_%0d", i), int'(dut.pending_q), exp_pend[i]);
      chk($sformatf("t35_ready_%0d", i), oTickReady, exp_rdy[i]);
    end
    iTickValid = 1'b0;
    wait_drained("t35_drained");
    chk("t35_tima", oTima, 8'h11);

    // Reset in ST_RELOAD with pending=7
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hFF);
    iTickValid = 1'b1; iTickCount = 3'd5;
    step(1);
    iTickValid = 1'b0;
    step(3);
    iTickValid = 1'b1; iTickCount = 3'd6;
    step(1);
    iTickValid = 1'b0;
    chk("t36_pending7", int'(dut.pending_q), 7);
    chk("t36_tima_zero", oTima, 8'h00);
    iReset = 1'b1; #1;
    chk("t36_pending0", int'(dut.pending_q), 0);
    chk("t36_ready", oTickReady, 1);
    chk("t36_tima", oTima, 0);
    chk("t36_div", oDiv, 0);
    chk("t36_irq", oInterrupt0x50, 0);
    iAddr = 2'd2; #1;
    chk("t36_tma", oRData, 8'h00);
    iAddr = 2'd3; #1;
    chk("t36_tac", oRData, 8'hF8);
    step(2);
    iReset = 1'b0;
    step(3);
    chk("t36_no_irq", irq_cnt, 1);
    chk("t36_tima_after", oTima, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
